// File: rtl/mac_op_driver.sv
// Initiator-side sequencer for the mac unit: buffers operand pairs in a FIFO,
// issues them over the start/finish handshake and holds each result for a consumer.
module mac_op_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned OP_W    = 8,
    parameter int unsigned RC_W    = 20,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_a,
    input  logic [OP_W-1:0]          in_b,
    output logic [OP_W-1:0]          op_a,
    output logic [OP_W-1:0]          op_b,
    output logic                     start,
    input  logic                     finish,
    input  logic [RC_W-1:0]          rc,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RC_W-1:0]          res_data,
    output logic                     timeout_err,
    input  logic                     err_clr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   mem_a [DEPTH];
    logic [OP_W-1:0]   mem_b [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [TW-1:0]     tcnt;
    logic              push;
    logic              pop;
    logic              tmo_hit;

    assign in_ready = (fill != FW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));
    // The head leaves only when ISSUE exits, so operands stay stable for the whole request
    assign pop      = (state == S_ISSUE) && (finish || tmo_hit);
    assign op_a     = mem_a[rd_ptr];
    assign op_b     = mem_b[rd_ptr];
    assign busy     = (state != S_IDLE) || (fill != '0);

    // Operand FIFO: power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= in_a;
                mem_b[wr_ptr] <= in_b;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Issue sequencer, result register and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start       <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
        end else begin
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if ((fill != '0) && !res_valid) begin
                        state <= S_ISSUE;
                        start <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (finish) begin
                        res_data  <= rc;
                        res_valid <= 1'b1;
                        start     <= 1'b0;
                        state     <= S_DONE;
                    end else if (tmo_hit) begin
                        start       <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                // One guaranteed low cycle of start on top of the DONE->IDLE cycle
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_op_driver.sv
// Self-checking bench for mac_op_driver with a behavioural mac model and a result scoreboard.
module tb_mac_op_driver;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned RC_W    = 20;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned FW      = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] in_a = '0;
    logic [OP_W-1:0] in_b = '0;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic            start;
    logic            finish;
    logic [RC_W-1:0] rc;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [RC_W-1:0] res_data;
    logic            timeout_err;
    logic            err_clr = 1'b0;
    logic            busy;
    logic [FW-1:0]   fill;

    int              n_chk = 0;
    int              n_bad = 0;
    logic [RC_W-1:0] exp_q [$];
    bit              stall = 1'b0;

    mac_op_driver #(
        .DEPTH(DEPTH), .OP_W(OP_W), .RC_W(RC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .op_a(op_a), .op_b(op_b), .start(start), .finish(finish), .rc(rc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mac model: answers a few cycles after seeing start, holds while stalled
    logic       mbusy;
    logic [2:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy  <= 1'b0;
            mcnt   <= '0;
            finish <= 1'b0;
            rc     <= '0;
        end else begin
            finish <= 1'b0;
            if (!mbusy) begin
                if (start) mbusy <= 1'b1;
                mcnt <= 3'd1;
            end else if (!start) begin
                mbusy <= 1'b0;
            end else if (mcnt < 3'd4) begin
                mcnt <= mcnt + 3'd1;
            end else if (mcnt == 3'd4 && !stall) begin
                finish <= 1'b1;
                rc     <= RC_W'(op_a) * RC_W'(op_b);
                mcnt   <= 3'd5;
            end
        end
    end

    // Scoreboard pop on each accepted result, plus operand stability while start is high
    logic                 prev_start = 1'b0;
    logic [2*OP_W-1:0]    held = '0;
    logic [RC_W-1:0]      exp_v;
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(exp_v));
            end
        end
        if (rst_n && start && prev_start) check("op_stable", 32'({op_a, op_b}), 32'(held));
        if (start && !prev_start) held <= {op_a, op_b};
        prev_start <= rst_n && start;
    end

    task automatic push_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input bit expect_res);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("push_wait", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        if (expect_res) exp_q.push_back(RC_W'(a) * RC_W'(b));
        #1;
        in_valid = 1'b0;
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0:       return res_valid;
            1:       return start;
            default: return (exp_q.size() == 0) && !busy;
        endcase
    endfunction

    task automatic wait_until(input int which, input int max, input string tag);
        int n = 0;
        while (!cond_met(which) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cond_met(which)) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", 32'(start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op", 32'({op_a, op_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pair: issue latency and result capture
        push_pair(8'd10, 8'd10, 1'b1);
        check("t1_start_at_push", 32'(start), 32'd0);
        @(posedge clk); #1;
        check("t1_start_next", 32'(start), 32'd1);
        wait_until(0, 30, "t1_res_timeout");
        check("t1_res_data", 32'(res_data), 32'd100);
        check("t1_start_low0", 32'(start), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("t1_start_low", 32'(start), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t1_res_cleared", 32'(res_valid), 32'd0);

        // Two pairs, zero-wait consumer
        push_pair(8'hFF, 8'hFF, 1'b1);
        push_pair(8'd4, 8'd2, 1'b1);
        wait_until(2, 200, "t2_drain");

        // Fill the FIFO behind a stalled mac, try an overflow, then drain with wrap
        stall = 1'b1;
        push_pair(8'd1, 8'd2, 1'b1);
        push_pair(8'd3, 8'd4, 1'b1);
        push_pair(8'd5, 8'd6, 1'b1);
        push_pair(8'd7, 8'd8, 1'b1);
        check("t3_fill_full", 32'(fill), 32'd4);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a     = 8'd99;
        in_b     = 8'd99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_no_overflow", 32'(fill), 32'd4);
        stall = 1'b0;
        wait_until(2, 300, "t3_drain");
        check("t3_fill_empty", 32'(fill), 32'd0);

        // Result backpressure blocks the next issue
        res_ready = 1'b0;
        push_pair(8'd2, 8'd3, 1'b1);
        push_pair(8'd5, 8'd5, 1'b1);
        wait_until(0, 50, "t4_res_timeout");
        repeat (8) begin
            @(posedge clk); #1;
            check("t4_hold_start", 32'(start), 32'd0);
        end
        check("t4_held_valid", 32'(res_valid), 32'd1);
        check("t4_fill", 32'(fill), 32'd1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_start_edge1", 32'(start), 32'd0);
        check("t4_valid_clr", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("t4_start_edge2", 32'(start), 32'd1);
        wait_until(2, 200, "t4_drain");

        // Timeout abort, then normal issue and error clear
        stall = 1'b1;
        push_pair(8'd9, 8'd9, 1'b0);
        wait_until(1, 10, "t5_start");
        n = 0;
        while (start && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("t5_start_cycles", 32'(n), 32'(TIMEOUT));
        check("t5_terr", 32'(timeout_err), 32'd1);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        check("t5_fill", 32'(fill), 32'd0);
        stall = 1'b0;
        push_pair(8'd3, 8'd7, 1'b1);
        wait_until(2, 200, "t5_drain");
        check("t5_terr_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("t5_terr_clr", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a request
        stall = 1'b1;
        push_pair(8'd11, 8'd12, 1'b0);
        push_pair(8'd13, 8'd14, 1'b0);
        push_pair(8'd15, 8'd16, 1'b0);
        wait_until(1, 10, "t6_start");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_start", 32'(start), 32'd0);
        check("t6_fill", 32'(fill), 32'd0);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_res_data", 32'(res_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle_after", 32'(start), 32'd0);
        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
